fetch_stage: RTL and testbench

//   Instruction-fetch stage of the pipelined ARM core. Owns the program counter and drives the

---
 rtl/arm_fetch_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/arm_fetch_pkg.sv
// +----------------------------------------------------------------------+
// | arm_fetch_pkg : shared types and constants for the ARM fetch stage    |
// | Revision      : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package arm_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // MOV r0,r0 fills the IF/ID slot whenever it holds no live instruction
  localparam logic [31:0] INSTR_NOP = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] PC_R15    = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// +----------------------------------------------------------------------+
// | fetch_stage_if : imem, redirect and IF/ID handshake bundle            |
// | Revision       : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus8;

  modport master (
    output imem_a, id_valid, id_instr, id_pc, id_pcplus8,
    input  imem_rd, branch_taken, branch_target, id_ready
  );

  modport slave (
    input  imem_a, id_valid, id_instr, id_pc, id_pcplus8,
    output imem_rd, branch_taken, branch_target, id_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// +----------------------------------------------------------------------+
// | if_id_reg : load/flush/hold pipeline register {valid,instr,pc,pc+8}   |
// | Revision  : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module if_id_reg
  import arm_fetch_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        i_load,
  input  wire logic        i_flush,
  input  wire logic [31:0] i_instr,
  input  wire logic [31:0] i_pc,
  input  wire logic [31:0] i_pcplus8,
  output logic             o_valid,
  output logic [31:0]      o_instr,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pcplus8
);

  // Flush wins over load; pc fields are left stale since valid=0 masks them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid   <= 1'b0;
      o_instr   <= INSTR_NOP;
      o_pc      <= 32'd0;
      o_pcplus8 <= 32'd0;
    end else if (i_flush) begin
      o_valid   <= 1'b0;
      o_instr   <= INSTR_NOP;
    end else if (i_load) begin
      o_valid   <= 1'b1;
      o_instr   <= i_instr;
      o_pc      <= i_pc;
      o_pcplus8 <= i_pcplus8;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +----------------------------------------------------------------------+
// | fetch_stage : PC, fetch FSM, redirect/flush and retired-fetch count   |
// | Revision    : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  fetch_stage_if.master         bus,
  output logic                  fetch_misalign,
  output logic [CNT_W-1:0]      fetch_count
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_count;

  logic             w_id_valid;
  logic             w_advance;
  logic             w_flush;
  logic             w_load;
  logic             w_xfer;
  logic [31:0]      w_pcplus8;

  assign w_advance = !w_id_valid || bus.id_ready;
  assign w_flush   = bus.branch_taken;
  assign w_load    = !w_flush && (r_state != BOOT) && w_advance;
  // A transfer coinciding with a redirect is discarded, so it is not counted
  assign w_xfer    = w_id_valid && bus.id_ready && !w_flush;
  assign w_pcplus8 = r_pc + PC_R15;

  assign bus.imem_a   = r_pc;
  assign bus.id_valid = w_id_valid;
  assign fetch_misalign = r_misalign;
  assign fetch_count    = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_xfer) begin
        r_count <= r_count + c_cnt_one;
      end
      if (w_flush) begin
        r_pc    <= word_align(bus.branch_target);
        r_state <= FETCH;
        if (bus.branch_target[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end else begin
        if (w_load) begin
          r_pc <= r_pc + PC_STEP;
        end
        r_state <= w_advance ? FETCH : HOLD;
      end
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_flush   (w_flush),
    .i_instr   (bus.imem_rd),
    .i_pc      (r_pc),
    .i_pcplus8 (w_pcplus8),
    .o_valid   (w_id_valid),
    .o_instr   (bus.id_instr),
    .o_pc      (bus.id_pc),
    .o_pcplus8 (bus.id_pcplus8)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +----------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage         |
// | Revision       : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic clk;
  logic reset_n;
  logic        misalign,  misalign2;
  logic [31:0] count,     count2;
  int checks;
  int failures;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  // imem contents: word at address a is {8'hA5, a[23:0]}
  assign bus.imem_rd  = {8'hA5, bus.imem_a[23:0]};
  assign bus2.imem_rd = {8'hA5, bus2.imem_a[23:0]};

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .fetch_misalign(misalign), .fetch_count(count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .fetch_misalign(misalign2), .fetch_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released at posedge+1; the next edge is the BOOT edge
  task automatic do_reset();
    reset_n = 1'b0;
    bus.id_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.id_instr !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", bus.id_instr, NOP); end
    checks++; if (bus.id_pc !== 32'd0 || bus.id_pcplus8 !== 32'd0) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0/0", bus.id_pc, bus.id_pcplus8); end
    checks++; if (bus.imem_a !== 32'd0) begin failures++; $display("FAIL rst_imem_a got=%h exp=0", bus.imem_a); end
    checks++; if (bus2.imem_a !== 32'hFFFF_FFF8) begin failures++; $display("FAIL rst_imem_a_wrap got=%h exp=fffffff8", bus2.imem_a); end
    checks++; if (count !== 32'd0 || misalign !== 1'b0) begin failures++; $display("FAIL rst_cnt_mis got=%0d/%b exp=0/0", count, misalign); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    step();
    checks++; if (bus.id_valid !== 1'b0 || bus.imem_a !== 32'd0) begin failures++; $display("FAIL boot_bubble got=%b/%h exp=0/0", bus.id_valid, bus.imem_a); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'(i * 4);
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc || bus.id_instr !== {8'hA5, exp_pc[23:0]} || bus.id_pcplus8 !== exp_pc + 32'd8) begin
        failures++;
        $display("FAIL stream_%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, bus.id_valid, bus.id_pc, bus.id_instr, bus.id_pcplus8, exp_pc, {8'hA5, exp_pc[23:0]}, exp_pc + 32'd8);
      end
      checks++; if (count !== 32'(i)) begin failures++; $display("FAIL stream_cnt_%0d got=%0d exp=%0d", i, count, i); end
    end
    step();
    checks++; if (count !== 32'd4) begin failures++; $display("FAIL stream_cnt_final got=%0d exp=4", count); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step(); step();
    checks++; if (bus.id_pc !== 32'h8 || count !== 32'd2) begin failures++; $display("FAIL stall_setup got=%h/%0d exp=8/2", bus.id_pc, count); end
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.id_instr !== 32'hA500_0008 || bus.imem_a !== 32'hC || count !== 32'd2) begin
        failures++;
        $display("FAIL stall_hold_%0d got=%b/%h/%h/%h/%0d exp=1/8/a5000008/c/2", i, bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_a, count);
      end
    end
    bus.id_ready = 1'b1;
    step();
    checks++; if (bus.id_pc !== 32'hC || bus.id_instr !== 32'hA500_000C || count !== 32'd3) begin failures++; $display("FAIL stall_release got=%h/%h/%0d exp=c/a500000c/3", bus.id_pc, bus.id_instr, count); end
    step();
    checks++; if (bus.id_pc !== 32'h10 || count !== 32'd4) begin failures++; $display("FAIL stall_after got=%h/%0d exp=10/4", bus.id_pc, count); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    step(); step(); step(); step();
    bus.id_ready = 1'b0;
    step();
    bus.id_ready = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h40;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP || bus.imem_a !== 32'h40) begin failures++; $display("FAIL flush got=%b/%h/%h exp=0/%h/40", bus.id_valid, bus.id_instr, bus.imem_a, NOP); end
    checks++; if (count !== 32'd2) begin failures++; $display("FAIL flush_cnt got=%0d exp=2", count); end
    step();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_instr !== 32'hA500_0040 || bus.id_pcplus8 !== 32'h48) begin failures++; $display("FAIL target got=%b/%h/%h/%h exp=1/40/a5000040/48", bus.id_valid, bus.id_pc, bus.id_instr, bus.id_pcplus8); end
    checks++; if (count !== 32'd2 || misalign !== 1'b0) begin failures++; $display("FAIL target_cnt got=%0d/%b exp=2/0", count, misalign); end
    step();
    checks++; if (bus.id_pc !== 32'h44 || count !== 32'd3) begin failures++; $display("FAIL target_next got=%h/%0d exp=44/3", bus.id_pc, count); end
  endtask

  task automatic test_misalign();
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h42;
    step();
    checks++; if (bus.imem_a !== 32'h40 || misalign !== 1'b1) begin failures++; $display("FAIL misalign got=%h/%b exp=40/1", bus.imem_a, misalign); end
    bus.branch_target = 32'h80;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.imem_a !== 32'h80 || misalign !== 1'b1) begin failures++; $display("FAIL misalign_sticky got=%h/%b exp=80/1", bus.imem_a, misalign); end
    step(); step();
    checks++; if (misalign !== 1'b1 || bus.id_pc !== 32'h84) begin failures++; $display("FAIL misalign_keep got=%b/%h exp=1/84", misalign, bus.id_pc); end
    reset_n = 1'b0;
    #1;
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step();
    step();
    checks++; if (bus2.id_pc !== 32'hFFFF_FFF8 || bus2.id_pcplus8 !== 32'h0000_0000) begin failures++; $display("FAIL wrap_0 got=%h/%h exp=fffffff8/0", bus2.id_pc, bus2.id_pcplus8); end
    step();
    checks++; if (bus2.id_pc !== 32'hFFFF_FFFC || bus2.id_pcplus8 !== 32'h0000_0004) begin failures++; $display("FAIL wrap_1 got=%h/%h exp=fffffffc/4", bus2.id_pc, bus2.id_pcplus8); end
    step();
    checks++; if (bus2.id_pc !== 32'h0 || bus2.id_instr !== 32'hA500_0000 || bus2.imem_a !== 32'h4) begin failures++; $display("FAIL wrap_2 got=%h/%h/%h exp=0/a5000000/4", bus2.id_pc, bus2.id_instr, bus2.imem_a); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(); step(); step(); step();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP || bus.id_pc !== 32'd0 || bus.id_pcplus8 !== 32'd0 || bus.imem_a !== 32'd0 || count !== 32'd0) begin
      failures++;
      $display("FAIL async_rst got=%b/%h/%h/%h/%h/%0d exp=0/%h/0/0/0/0", bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pcplus8, bus.imem_a, count, NOP);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (bus.id_valid !== 1'b0 || bus.imem_a !== 32'd0) begin failures++; $display("FAIL async_boot got=%b/%h exp=0/0", bus.id_valid, bus.imem_a); end
    step();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd0 || bus.id_instr !== 32'hA500_0000) begin failures++; $display("FAIL async_first got=%b/%h/%h exp=1/0/a5000000", bus.id_valid, bus.id_pc, bus.id_instr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    bus.id_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    bus2.id_ready = 1'b1;
    bus2.branch_taken = 1'b0;
    bus2.branch_target = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_misalign();
    test_pc_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
